reg_bank_sched: RTL and testbench
=================================

# reg_bank_sched

Write scheduler for a bank of am25ls08 registers shared between two requesters. Arbitrates round-robin between two write ports, stages the winning address/data for one cycle, then drives the selected register's active-low enable so it loads on the next clock. Provides an asynchronous read port with true and complemented data, matching the am25ls08 q/q_ pair. Sits between two microcode-driven producers and the register bank in bitslice datapath models.

## Interface
- WIDTH, 4, data width of each register
- NREG, 4, number of registers in the bank
- AW, 2, address width; NREG <= 2**AW
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 write request
- addr0  in  AW  requester 0 target register
- d0  in  WIDTH  requester 0 write data
- ack0  out  1  requester 0 accept pulse
- req1, addr1, d1, ack1: same for requester 1
- raddr  in  AW  read address
- rdata  out  WIDTH  q of register raddr
- rdata_  out  WIDTH  q_ of register raddr, always ~rdata
- we_  out  NREG  per-register enable, active-low, at most one bit low
- busy  out  1  staged write pending (st_valid)

## Operation
- State: ack0, ack1, last (id of last granted requester), st_valid, st_addr, st_data.
- Eligibility: reqN is eligible only when reqN=1 and ackN=0. A held request is not re-accepted during its ack cycle, so one requester gets at most one accept per 2 cycles.
- Arbitration at each edge:
  - One eligible: it wins.
  - Both eligible: the requester != last wins.
  - Winner: ackN<=1, last<=N, st_valid<=1, st_addr<=addrN, st_data<=dN.
  - No eligible: st_valid<=0, both acks 0.
  - Loser's ack stays 0.
- Ack is a one-cycle pulse. The requester either drops req or presents new addr/data before the next edge; this is then accepted on the following edge at the earliest.
- Enable decode: we_[st_addr]=0 while st_valid=1 and st_addr<NREG, else all 1. Out-of-range st_addr writes nothing but is still acked.
- Registers: NREG am25ls08 instances, WIDTH wide. d=st_data, e_=we_[i]. No reset on register contents (part fidelity); contents are X until first write.
- Read path: combinational mux of q/q_ by raddr. raddr >= NREG gives all X.
- Same-address collision: both requesters write the same register in the same cycle. The winner's data loads first, the loser's one edge later, so the loser's value persists. The order follows round-robin.

## Timing
- Reset values: ack0=ack1=0, st_valid=0, busy=0, we_=all 1, last=1 (requester 0 wins first contention).
- Reset asserted mid-operation clears st_valid immediately, so we_ goes all 1 asynchronously and the staged write is dropped. A pending ack is cleared.
- Write latency:
  - Request sampled at edge E0: ack and we_ low during E0..E1.
  - Register loads at E1; rdata reflects it after E1.
- Throughput: one write per cycle when both requesters alternate; one per 2 cycles per requester alone.
- rdata/rdata_ change combinationally with raddr and with register q after E1.

## Structure
- No shared package needed.
- Plain Verilog localparams for requester ids (R0=0, R1=1) inside the module.
- Reuses the existing am25ls08 module via generate loop, one WIDTH-bit instance per register. No new sub-module.
- Arbiter, staging register and enable decode stay in this module.
- Estimated at 120-200 lines.

## Test plan
- Reset then single write: req0=1, addr0=2, d0=1010 for one edge. Required:
  - ack0 pulses one cycle and we_=1011 for that cycle.
  - After the next edge, raddr=2 gives rdata=1010, rdata_=0101.
- Contention after reset: req0 (addr 0, 0011) and req1 (addr 1, 1100) held. Required:
  - ack0 first, then ack1 the next cycle.
  - Reg0=0011, reg1=1100.
  - With both held continuously: acks alternate 0,1,0,1.
- Same-address collision: both requesters target addr 3, d0=1111, d1=0000, last=0. Required:
  - Requester 1 granted first, then requester 0.
  - Final reg3=1111.
- Held request: req0 held high for 4 edges, data constant 0101. Required:
  - ack0 pattern 1,0,1,0.
  - we_ low only in ack cycles.
  - Reg value 0101.
- Idle hold: no requests for 5 cycles after writes. Required:
  - we_ stays all 1, busy=0.
  - All written register values unchanged on every raddr.
- Reset mid-write: assert rst while busy=1 with st_data=0110, and the target register holds 1001. Required:
  - we_ goes all 1 immediately and ack0/ack1=0.
  - Register still reads 1001 after the following clock edges.

Source files
------------

// File: rtl/am25ls08.sv
// Behavioural am25ls08: WIDTH-bit register with active-low load enable and
// complementary outputs. Contents are deliberately left unreset, as on the part.
module am25ls08 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             e_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_
);

  always_ff @(posedge clk)
    if (!e_) q <= d;

  assign q_ = ~q;

endmodule

// File: rtl/reg_bank_sched.sv
// Two-port round-robin write scheduler in front of a bank of am25ls08 registers,
// with one staging cycle before the enable and a combinational q/q_ read port.
module reg_bank_sched #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] d0,
  output logic             ack0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack1,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] rdata_,
  output logic [NREG-1:0]  we_,
  output logic             busy
);

  localparam logic R0 = 1'b0;
  localparam logic R1 = 1'b1;

  logic             last;
  logic             st_valid;
  logic [AW-1:0]    st_addr;
  logic [WIDTH-1:0] st_data;
  logic             elig0, elig1, gnt0, gnt1;
  logic [WIDTH-1:0] q  [NREG];
  logic [WIDTH-1:0] qn [NREG];

  // A requester in its ack cycle is still showing the request just taken,
  // so it sits out this edge.
  always_comb begin
    elig0 = req0 && !ack0;
    elig1 = req1 && !ack1;
    gnt0  = elig0 && (!elig1 || last == R1);
    gnt1  = elig1 && (!elig0 || last == R0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      last     <= R1;
      st_valid <= 1'b0;
      st_addr  <= '0;
      st_data  <= '0;
    end else begin
      ack0     <= gnt0;
      ack1     <= gnt1;
      st_valid <= gnt0 || gnt1;
      if (gnt0) begin
        last    <= R0;
        st_addr <= addr0;
        st_data <= d0;
      end else if (gnt1) begin
        last    <= R1;
        st_addr <= addr1;
        st_data <= d1;
      end
    end
  end

  assign busy = st_valid;

  // Out-of-range staged addresses match no decode term and write nothing.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign we_[i] = ~(st_valid && st_addr == AW'(i));
    am25ls08 #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .e_  (we_[i]),
      .d   (st_data),
      .q   (q[i]),
      .q_  (qn[i])
    );
  end

  always_comb begin
    rdata  = 'x;
    rdata_ = 'x;
    if ({1'b0, raddr} < (AW+1)'(NREG)) begin
      rdata  = q[raddr];
      rdata_ = qn[raddr];
    end
  end

endmodule

// File: tb/tb_reg_bank_sched.sv
// Scoreboarded bench for reg_bank_sched: directed scenarios then random traffic,
// checked against a round-robin / memory-array model.
module tb_reg_bank_sched;
  localparam int WIDTH = 4;
  localparam int NREG  = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [AW-1:0]    addr0, addr1, raddr;
  logic [WIDTH-1:0] d0, d1, rdata, rdata_;
  logic             ack0, ack1, busy;
  logic [NREG-1:0]  we_;

  reg_bank_sched #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .d0(d0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .d1(d1), .ack1(ack1),
    .raddr(raddr), .rdata(rdata), .rdata_(rdata_),
    .we_(we_), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            a0;
    logic            a1;
    logic            busy;
    logic [NREG-1:0] we;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: who was served last, what is in flight, what each register holds.
  logic [WIDTH-1:0] mmem [NREG];
  bit               mknown [NREG];
  bit               m_ack0, m_ack1, m_last, m_stv;
  int               m_sta;
  logic [WIDTH-1:0] m_std;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.a0   = m_ack0;
    e.a1   = m_ack1;
    e.busy = m_stv;
    e.we   = '1;
    if (m_stv && m_sta < NREG) e.we[m_sta] = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_ack0 = 0; m_ack1 = 0; m_last = 1; m_stv = 0;
  endtask

  task automatic model_step();
    bit e0, e1;
    int w;
    if (rst) model_reset();
    else begin
      if (m_stv && m_sta < NREG) begin
        mmem[m_sta]   = m_std;
        mknown[m_sta] = 1;
      end
      e0 = req0 && !m_ack0;
      e1 = req1 && !m_ack1;
      w  = -1;
      if (e0 && e1) w = m_last ? 0 : 1;
      else if (e0)  w = 0;
      else if (e1)  w = 1;
      m_ack0 = (w == 0);
      m_ack1 = (w == 1);
      m_stv  = (w >= 0);
      if (w == 0) begin m_last = 0; m_sta = int'(addr0); m_std = d0; end
      if (w == 1) begin m_last = 1; m_sta = int'(addr1); m_std = d1; end
    end
    exp_q.push_back(model_expect());
  endtask

  // One clock: model follows the edge, inputs may change 2 time units later.
  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_expect());
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [WIDTH-1:0] want, input string name);
    logic [WIDTH-1:0] inv;
    raddr = a;
    #1;
    inv = ~want;
    chk(name, rdata, want);
    chk({name, "_n"}, rdata_, inv);
  endtask

  exp_t             mon_e;
  logic [WIDTH-1:0] mon_inv;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_ack0", ack0, mon_e.a0);
      chk("sb_ack1", ack1, mon_e.a1);
      chk("sb_busy", busy, mon_e.busy);
      chk("sb_we_",  we_,  mon_e.we);
    end
    if (!rst && mknown[raddr]) begin
      mon_inv = ~mmem[raddr];
      chk("sb_rdata",  rdata,  mmem[raddr]);
      chk("sb_rdata_", rdata_, mon_inv);
    end
  end

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; d0 = 0; d1 = 0; raddr = 0;
    model_reset();
    repeat (2) step();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we_",  we_,  4'hF);
    rst = 1'b0;

    // single write
    req0 = 1; addr0 = 2; d0 = 4'b1010;
    step();
    chk("t1_ack0", ack0, 1);
    chk("t1_we_",  we_,  4'b1011);
    req0 = 0;
    step();
    chk("t1_ack0_off", ack0, 0);
    rd(2, 4'b1010, "t1_rd");

    // contention after reset, then same-address collision with last=0
    apply_reset();
    step();
    rst = 1'b0;
    req0 = 1; addr0 = 0; d0 = 4'b0011;
    req1 = 1; addr1 = 1; d1 = 4'b1100;
    step(); chk("t2_a0_e1", ack0, 1); chk("t2_a1_e1", ack1, 0);
    step(); chk("t2_a0_e2", ack0, 0); chk("t2_a1_e2", ack1, 1);
    step(); chk("t2_a0_e3", ack0, 1); chk("t2_a1_e3", ack1, 0);
    addr0 = 3; d0 = 4'b1111; addr1 = 3; d1 = 4'b0000;
    step(); chk("t3_a1_first", ack1, 1); chk("t3_a0_first", ack0, 0);
    step(); chk("t3_a0_second", ack0, 1); chk("t3_a1_second", ack1, 0);
    req0 = 0; req1 = 0;
    step();
    step();
    rd(0, 4'b0011, "t2_reg0");
    rd(1, 4'b1100, "t2_reg1");
    rd(3, 4'b1111, "t3_reg3");

    // held request from requester 0 alone
    req0 = 1; addr0 = 1; d0 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_ack0", ack0, (i % 2 == 0) ? 1 : 0);
      chk("t4_we_",  we_,  (i % 2 == 0) ? 4'b1101 : 4'b1111);
    end
    req0 = 0;
    step();
    rd(1, 4'b0101, "t4_reg1");

    // idle hold
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_we_",  we_,  4'hF);
      chk("t5_busy", busy, 0);
    end
    rd(0, 4'b0011, "t5_reg0");
    rd(1, 4'b0101, "t5_reg1");
    rd(2, 4'b1010, "t5_reg2");
    rd(3, 4'b1111, "t5_reg3");

    // reset while a write is staged
    req0 = 1; addr0 = 2; d0 = 4'b1001;
    step();
    req0 = 0;
    step();
    rd(2, 4'b1001, "t6_pre");
    req0 = 1; d0 = 4'b0110;
    step();
    chk("t6_busy", busy, 1);
    req0 = 0;
    apply_reset();
    chk("t6_we_",  we_,  4'hF);
    chk("t6_ack0", ack0, 0);
    chk("t6_ack1", ack1, 0);
    chk("t6_busy_rst", busy, 0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    rd(2, 4'b1001, "t6_kept");

    // random traffic
    repeat (400) begin
      req0  = 1'($urandom_range(0, 1));
      req1  = 1'($urandom_range(0, 1));
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      d0    = WIDTH'($urandom);
      d1    = WIDTH'($urandom);
      raddr = AW'($urandom);
      step();
    end
    req0 = 0; req1 = 0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
